// File: rtl/sdram_block_reader_if.sv
// ---------------------------------------------------------------------------
// sdram_block_reader_if
// Bundles the Avalon-MM read-master signals and the outgoing valid/ready
// stream of sdram_block_reader.
//   master : the block reader (drives avm_address/avm_read, st_data/st_valid)
//   slave  : the SDRAM port plus stream sink (drives waitrequest/readdata/
//            readdatavalid and st_ready)
// ---------------------------------------------------------------------------
interface sdram_block_reader_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;
   logic [DATA_W-1:0] st_data;
   logic              st_valid;
   logic              st_ready;

   modport master (
      output avm_address, avm_read,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      output st_data, st_valid,
      input  st_ready
   );

   modport slave (
      input  avm_address, avm_read,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  st_data, st_valid,
      output st_ready
   );
endinterface

// File: rtl/sdram_block_reader.sv
// ---------------------------------------------------------------------------
// sdram_block_reader
// Avalon-MM read master that fetches num_words consecutive DATA_W-bit words
// starting at base_addr and returns them, in request order, on a valid/ready
// stream. Outstanding reads plus buffered words never exceed FIFO_DEPTH, so
// the return FIFO cannot overflow.
// Ports:
//   clk_clk, reset_reset_n    : clock, asynchronous active-low reset
//   start/base_addr/num_words : block request, sampled in IDLE only
//   busy                      : block in progress
//   done                      : one-cycle completion pulse
//   bus (master modport)      : avm_* read master and st_* stream source
// ---------------------------------------------------------------------------
module sdram_block_reader #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [LEN_W-1:0]      num_words,
   output logic                  busy,
   output logic                  done,
   sdram_block_reader_if.master  bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_done, w_done_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len, r_issued, r_delivered;
   logic [CW-1:0]     r_pending;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr, r_rptr;
   logic [CW-1:0]     r_count;

   logic w_accept, w_credit_ok, w_read, w_xfer, w_push, w_pop;
   logic w_last_xfer, w_last_pop;

   // Credit: every outstanding read already owns a FIFO slot. While a read is
   // stalled, pending+count cannot grow (a push moves one unit from pending to
   // count, a pop only shrinks it), so avm_read is never retracted.
   always_comb begin
      w_credit_ok = ({1'b0, r_pending} + {1'b0, r_count}) < (CW+1)'(FIFO_DEPTH);
      w_read      = (r_state == ST_ISSUE) && (r_issued < r_len) && w_credit_ok;
      w_xfer      = w_read && !bus.avm_waitrequest;
      w_push      = bus.avm_readdatavalid;
      w_pop       = (r_count != '0) && bus.st_ready;
      w_last_xfer = w_xfer && (r_issued == r_len - LEN_W'(1));
      w_last_pop  = w_pop && (r_delivered == r_len - LEN_W'(1));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (w_last_xfer) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_last_pop) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state     <= ST_IDLE;
         r_done      <= 1'b0;
         r_addr      <= '0;
         r_len       <= '0;
         r_issued    <= '0;
         r_delivered <= '0;
         r_pending   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_done    <= w_done_nxt;
         r_pending <= r_pending + {{(CW-1){1'b0}}, w_xfer} - {{(CW-1){1'b0}}, w_push};
         if (w_accept) begin
            r_addr      <= base_addr;
            r_len       <= num_words;
            r_issued    <= '0;
            r_delivered <= '0;
         end else begin
            if (w_xfer) begin
               r_addr   <= r_addr + STRIDE;
               r_issued <= r_issued + LEN_W'(1);
            end
            if (w_pop) r_delivered <= r_delivered + LEN_W'(1);
         end
      end
   end

   // Return FIFO
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (w_push) r_mem[r_wptr] <= bus.avm_readdata;
   end

   a_no_overflow : assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
      !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))))
      else $error("sdram_block_reader: push into full return FIFO");

   assign busy            = (r_state != ST_IDLE);
   assign done            = r_done;
   assign bus.avm_address = r_addr;
   assign bus.avm_read    = w_read;
   assign bus.st_data     = r_mem[r_rptr];
   assign bus.st_valid    = (r_count != '0);

endmodule

// File: tb/tb_sdram_block_reader.sv
module tb_sdram_block_reader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] num_words;
   logic        busy, done;

   sdram_block_reader_if #(.ADDR_W(32), .DATA_W(64)) bif ();

   sdram_block_reader #(.ADDR_W(32), .DATA_W(64), .LEN_W(16), .FIFO_DEPTH(16)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .start         (start),
      .base_addr     (base_addr),
      .num_words     (num_words),
      .busy          (busy),
      .done          (done),
      .bus           (bif)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory contents as a pure function of the byte address.
   function automatic logic [63:0] mem_f(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, a * 32'h9E37_79B1};
   endfunction

   // Reference: the block is the address list base+8*i (mod 2^32) and the
   // stream is mem_f of those addresses, in that order.
   logic [31:0] exp_addr[$];
   logic [63:0] exp_data[$];

   typedef struct { logic [63:0] d; int unsigned due; } resp_t;
   resp_t rq[$];

   // Slave / sink behaviour knobs
   int unsigned lat       = 1;
   int unsigned wr_prob   = 0;
   int unsigned rdy_prob  = 100;
   bit          rdy_hold  = 0;
   int          stall_idx = -1;
   int unsigned stall_cnt = 0;

   // Per-block observations
   int unsigned cyc = 0;
   int unsigned last_due = 0;
   int unsigned done_seen = 0;
   int          blk_xfers = 0;
   int          blk_pops  = 0;
   int          blk_reads = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_addr;
   logic        wr, rdy;

   // Avalon slave + stream sink, acting at the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (rst_n !== 1'b1) begin
         exp_addr.delete();
         exp_data.delete();
         rq.delete();
         prev_stall = 0;
         bif.avm_waitrequest   = 1'b0;
         bif.avm_readdatavalid = 1'b0;
         bif.avm_readdata      = '0;
         bif.st_ready          = 1'b0;
      end else begin
         if (done === 1'b1) done_seen++;
         if (prev_stall) begin
            chk("hold_read", bif.avm_read, 1'b1);
            chk("hold_addr", bif.avm_address, prev_addr);
         end
         if (bif.avm_read === 1'b1) begin
            blk_reads++;
            if (stall_idx == blk_xfers && stall_cnt < 3) begin
               wr = 1'b1;
               stall_cnt++;
            end else begin
               wr = ($urandom_range(99) < wr_prob);
            end
         end else begin
            wr = $urandom_range(1);
         end
         bif.avm_waitrequest = wr;
         if (bif.avm_read === 1'b1 && !wr) begin
            blk_xfers++;
            chk("credit", ((blk_xfers - blk_pops) <= 16), 1'b1);
            if (exp_addr.size() == 0) chk("extra_read", 1'b1, 1'b0);
            else chk("avm_address", bif.avm_address, exp_addr.pop_front());
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            rq.push_back('{d: mem_f(bif.avm_address), due: last_due});
         end
         prev_stall = (bif.avm_read === 1'b1) && wr;
         prev_addr  = bif.avm_address;
         if (rq.size() != 0 && rq[0].due <= cyc) begin
            bif.avm_readdatavalid = 1'b1;
            bif.avm_readdata      = rq[0].d;
            void'(rq.pop_front());
         end else begin
            bif.avm_readdatavalid = 1'b0;
            bif.avm_readdata      = {$urandom(), $urandom()};
         end
         rdy = !rdy_hold && ($urandom_range(99) < rdy_prob);
         bif.st_ready = rdy;
         if (bif.st_valid === 1'b1 && rdy) begin
            blk_pops++;
            if (exp_data.size() == 0) chk("extra_word", 1'b1, 1'b0);
            else chk("st_data", bif.st_data, exp_data.pop_front());
         end
      end
   end

   int unsigned d0;

   task automatic begin_block(input logic [31:0] b, input int unsigned n);
      logic [31:0] a;
      for (int unsigned i = 0; i < n; i++) begin
         a = b + 32'(i * 8);
         exp_addr.push_back(a);
         exp_data.push_back(mem_f(a));
      end
      d0 = done_seen;
      blk_xfers = 0; blk_pops = 0; blk_reads = 0; stall_cnt = 0;
      start = 1'b1; base_addr = b; num_words = 16'(n);
      @(posedge clk); #1;
      start = 1'b0; base_addr = $urandom(); num_words = 16'($urandom());
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic finish_block(input int unsigned n);
      int unsigned k = 0;
      while (done !== 1'b1 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_pulse", done, 1'b1);
      chk("busy_at_done", busy, 1'b0);
      @(posedge clk); #1;
      chk("done_single", done, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("done_count", done_seen - d0, 1);
      chk("reads_issued", blk_xfers, n);
      chk("words_left", exp_data.size(), 0);
      chk("st_valid_idle", bif.st_valid, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_read", bif.avm_read, 1'b0);
      chk("rst_addr", bif.avm_address, 32'h0);
      chk("rst_valid", bif.st_valid, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 4-word block, 2-cycle latency
      lat = 2; wr_prob = 0; rdy_prob = 100;
      begin_block(32'h1000, 4);
      finish_block(4);

      // Zero-length request
      d0 = done_seen; blk_reads = 0;
      start = 1'b1; base_addr = 32'h4000; num_words = 16'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_done", done, 1'b1);
      chk("zero_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("zero_done_single", done, 1'b0);
      chk("zero_busy_after", busy, 1'b0);
      chk("zero_no_read", blk_reads, 0);

      // Three waitrequest cycles on the second read
      lat = 1; stall_idx = 1;
      begin_block(32'h1000, 6);
      finish_block(6);
      chk("stall_cycles", stall_cnt, 3);
      stall_idx = -1;

      // Sink back-pressure: issue must stop at the FIFO depth
      rdy_hold = 1;
      begin_block(32'h8000, 40);
      repeat (60) @(posedge clk);
      #1;
      chk("bp_issued", blk_xfers, 16);
      chk("bp_valid", bif.st_valid, 1'b1);
      chk("bp_busy", busy, 1'b1);
      rdy_hold = 0;
      finish_block(40);

      // Address wrap
      lat = 3;
      begin_block(32'hFFFF_FFF8, 2);
      finish_block(2);

      // Busy start is ignored
      lat = 1; rdy_prob = 60;
      begin_block(32'h5000, 10);
      start = 1'b1; base_addr = 32'h9000; num_words = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      finish_block(10);

      // Reset mid-block
      lat = 2; rdy_prob = 100;
      begin_block(32'h3000, 30);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_read", bif.avm_read, 1'b0);
      chk("mid_rst_addr", bif.avm_address, 32'h0);
      chk("mid_rst_valid", bif.st_valid, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      begin_block(32'h2000, 3);
      finish_block(3);

      // Randomized blocks
      for (int t = 0; t < 8; t++) begin
         int unsigned n;
         logic [31:0] b;
         b        = $urandom() & 32'hFFFF_FFF8;
         n        = $urandom_range(50, 1);
         lat      = $urandom_range(4, 1);
         wr_prob  = $urandom_range(50, 0);
         rdy_prob = $urandom_range(100, 30);
         begin_block(b, n);
         finish_block(n);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
